// File: rtl/dnn_pkg.sv
// Shared types and helpers for the digit-classifier dense stages.
package dnn_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // Wide enough for any accumulator this family uses.
  localparam int unsigned SatW = 64;

  // ROM bytes are offset-binary.
  function automatic logic signed [7:0] ob_decode(input logic [7:0] b);
    return $signed(b ^ 8'h80);
  endfunction

  function automatic logic signed [SatW-1:0] sat_relu(input logic signed [SatW-1:0] v,
                                                       input logic relu_on,
                                                       input int unsigned out_bits);
    logic signed [SatW-1:0] hi;
    logic signed [SatW-1:0] lo;
    hi = (SatW'(1) <<< (out_bits - 1)) - 1;
    lo = -hi - 1;
    if (relu_on && v < 0) return '0;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Each row is N_IN weights followed by one bias byte.
  function automatic int unsigned row_base(input int unsigned j, input int unsigned n_in);
    return j * (n_in + 1);
  endfunction

endpackage

// File: rtl/dense_layer_hidden_if.sv
// Activation, ROM and result bundle for the hidden dense layer.
interface dense_layer_hidden_if #(
  parameter int unsigned N_IN       = 32,
  parameter int unsigned N_OUT      = 10,
  parameter int unsigned IN_BITS    = 16,
  parameter int unsigned OUT_BITS   = 16,
  parameter int unsigned ADDR_WIDTH = 12
);
  localparam int unsigned ClsW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic                               start;
  logic [N_IN-1:0][IN_BITS-1:0]       in_act;
  logic [7:0]                         mem_dout;
  logic [ADDR_WIDTH-1:0]              mem_addr;
  logic [N_OUT-1:0][OUT_BITS-1:0]     out_act;
  logic [ClsW-1:0]                    class_idx;
  logic                               finish;

  modport master (
    output start, in_act, mem_dout,
    input  mem_addr, out_act, class_idx, finish
  );

  modport slave (
    input  start, in_act, mem_dout,
    output mem_addr, out_act, class_idx, finish
  );
endinterface

// File: rtl/dnn_argmax_tracker.sv
// Running maximum with index; load restarts the search, update keeps the first of any tie.
module dnn_argmax_tracker #(
  parameter int unsigned Width = 16,
  parameter int unsigned IdxW  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic                    update_i,
  input  logic signed [Width-1:0] value_i,
  input  logic [IdxW-1:0]         idx_i,
  output logic [IdxW-1:0]         idx_o
);
  logic signed [Width-1:0] max_q;
  logic [IdxW-1:0]         idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q <= '0;
      idx_q <= '0;
    end else if (load_i || (update_i && (value_i > max_q))) begin
      max_q <= value_i;
      idx_q <= idx_i;
    end
  end

  assign idx_o = idx_q;
endmodule

// File: rtl/dense_layer_hidden.sv
// Second dense stage: streams one weight byte per cycle, writes saturated outputs row by row
// and tracks the argmax so the class is ready when finish pulses.
module dense_layer_hidden
  import dnn_pkg::*;
#(
  parameter int unsigned N_IN       = 32,
  parameter int unsigned N_OUT      = 10,
  parameter int unsigned IN_BITS    = 16,
  parameter int unsigned OUT_BITS   = 16,
  parameter int unsigned ACC_BITS   = 32,
  parameter int unsigned SHIFT      = 8,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned RELU_ON    = 0
) (
  input logic                 clk,
  input logic                 rst,
  dense_layer_hidden_if.slave bus
);
  localparam int unsigned Total = N_OUT * (N_IN + 1);
  localparam int unsigned IW    = $clog2(N_IN + 1);
  localparam int unsigned SelW  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int unsigned PW    = IN_BITS + 8;

  state_e                         state_q;
  logic [ADDR_WIDTH-1:0]          k_q;
  logic [IW-1:0]                  i_q;
  logic [JW-1:0]                  j_q;
  logic signed [ACC_BITS-1:0]     acc_q;
  logic signed [ACC_BITS-1:0]     acc_d;
  logic [N_IN-1:0][IN_BITS-1:0]   in_q;
  logic [N_OUT-1:0][OUT_BITS-1:0] out_q;
  logic                           finish_q;

  logic signed [7:0]              w;
  logic signed [PW-1:0]           prod;
  logic signed [ACC_BITS-1:0]     y;
  logic signed [OUT_BITS-1:0]     y_sat;
  logic                           is_bias;
  logic                           last;
  logic [ADDR_WIDTH-1:0]          mem_addr;
  logic [JW-1:0]                  cls;

  assign is_bias = (i_q == IW'(N_IN));
  assign last    = (k_q == ADDR_WIDTH'(Total - 1));

  always_comb begin
    w     = ob_decode(bus.mem_dout);
    prod  = $signed(in_q[i_q[SelW-1:0]]) * w;
    // First weight of a row overwrites the previous row's sum.
    acc_d = (i_q == '0) ? ACC_BITS'(prod) : acc_q + ACC_BITS'(prod);
    y     = (acc_q >>> SHIFT) + ACC_BITS'(w);
    y_sat = OUT_BITS'(sat_relu(SatW'(y), RELU_ON != 0, OUT_BITS));
  end

  always_comb begin
    mem_addr = '0;
    if (state_q == StRun && !last) mem_addr = k_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      k_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      acc_q    <= '0;
      in_q     <= '0;
      out_q    <= '0;
      finish_q <= 1'b0;
    end else begin
      finish_q <= (state_q == StDone);
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            in_q    <= bus.in_act;
            k_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          k_q <= k_q + 1'b1;
          if (is_bias) begin
            out_q[j_q] <= y_sat;
            i_q        <= '0;
            j_q        <= j_q + 1'b1;
          end else begin
            acc_q <= acc_d;
            i_q   <= i_q + 1'b1;
          end
          if (last) state_q <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  dnn_argmax_tracker #(
    .Width (OUT_BITS),
    .IdxW  (JW)
  ) u_argmax (
    .clk      (clk),
    .rst      (rst),
    .load_i   ((state_q == StRun) && is_bias && (j_q == '0)),
    .update_i ((state_q == StRun) && is_bias && (j_q != '0)),
    .value_i  (y_sat),
    .idx_i    (j_q),
    .idx_o    (cls)
  );

  assign bus.mem_addr  = mem_addr;
  assign bus.out_act   = out_q;
  assign bus.class_idx = cls;
  assign bus.finish    = finish_q;
endmodule

// File: tb/tb_dense_layer_hidden.sv
// Three layer instances (shift 8, shift 8 with ReLU, shift 0) share one ROM and input set.
module tb_dense_layer_hidden;
  import dnn_pkg::*;

  localparam int unsigned NIn  = 4;
  localparam int unsigned NOut = 3;

  typedef struct {
    int ea[3]; int ca;
    int er[3]; int cr;
    int es[3]; int cs;
    int fin;
  } exp_t;

  typedef struct {
    int         in_v[4];
    logic [7:0] w[3];
    logic [7:0] b[3];
    exp_t       e;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [NIn-1:0][15:0] in_act = '0;
  logic [7:0]           rom [16];
  int                   cyc = 0;
  int                   checks = 0;
  int                   failures = 0;
  exp_t                 sb[$];
  vec_t                 vecs[$];
  exp_t                 mon_e;

  dense_layer_hidden_if #(.N_IN(NIn), .N_OUT(NOut), .IN_BITS(16), .OUT_BITS(16),
                          .ADDR_WIDTH(12)) bus_a(), bus_r(), bus_s();

  assign bus_a.start = start;
  assign bus_r.start = start;
  assign bus_s.start = start;
  assign bus_a.in_act = in_act;
  assign bus_r.in_act = in_act;
  assign bus_s.in_act = in_act;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    bus_a.mem_dout <= rom[bus_a.mem_addr[3:0]];
    bus_r.mem_dout <= rom[bus_r.mem_addr[3:0]];
    bus_s.mem_dout <= rom[bus_s.mem_addr[3:0]];
  end

  dense_layer_hidden #(.N_IN(NIn), .N_OUT(NOut), .IN_BITS(16), .OUT_BITS(16), .ACC_BITS(32),
                       .SHIFT(8), .ADDR_WIDTH(12), .RELU_ON(0))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  dense_layer_hidden #(.N_IN(NIn), .N_OUT(NOut), .IN_BITS(16), .OUT_BITS(16), .ACC_BITS(32),
                       .SHIFT(8), .ADDR_WIDTH(12), .RELU_ON(1))
    dut_r (.clk(clk), .rst(rst), .bus(bus_r));
  dense_layer_hidden #(.N_IN(NIn), .N_OUT(NOut), .IN_BITS(16), .OUT_BITS(16), .ACC_BITS(32),
                       .SHIFT(0), .ADDR_WIDTH(12), .RELU_ON(0))
    dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [2:0][15:0] o, input logic [1:0] c,
                          input int eo[3], input int ec);
    logic [1:0] jx;
    for (int j = 0; j < 3; j++) begin
      jx = 2'(j);
      chk($sformatf("%s_out%0d", tag, j), int'($signed(o[jx])), eo[j]);
    end
    chk($sformatf("%s_class", tag), int'(c), ec);
  endtask

  always @(negedge clk) begin
    if (!rst && bus_a.finish) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_finish got=1 exp=0 (cyc %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("latency", cyc, mon_e.fin);
        chk("finish_r", int'(bus_r.finish), 1);
        chk("finish_s", int'(bus_s.finish), 1);
        chk_outs("a", bus_a.out_act, bus_a.class_idx, mon_e.ea, mon_e.ca);
        chk_outs("r", bus_r.out_act, bus_r.class_idx, mon_e.er, mon_e.cr);
        chk_outs("s", bus_s.out_act, bus_s.class_idx, mon_e.es, mon_e.cs);
      end
    end
  end

  task automatic add_vec(input int i0, input int i1, input int i2, input int i3,
                         input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                         input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input int a0, input int a1, input int a2, input int ca,
                         input int r0, input int r1, input int r2, input int cr,
                         input int s0, input int s1, input int s2, input int cs);
    vec_t v;
    v.in_v = '{i0, i1, i2, i3};
    v.w    = '{w0, w1, w2};
    v.b    = '{b0, b1, b2};
    v.e.ea = '{a0, a1, a2}; v.e.ca = ca;
    v.e.er = '{r0, r1, r2}; v.e.cr = cr;
    v.e.es = '{s0, s1, s2}; v.e.cs = cs;
    v.e.fin = 0;
    vecs.push_back(v);
  endtask

  task automatic load_vec(input vec_t v);
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 4; i++) rom[4'(row_base(j, NIn) + i)] = v.w[j];
      rom[4'(row_base(j, NIn) + NIn)] = v.b[j];
    end
    for (int i = 0; i < 4; i++) in_act[2'(i)] = 16'(v.in_v[i]);
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && sb.size() != 0; t++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout got=%0d_pending exp=0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input bit glitch);
    exp_t e;
    load_vec(v);
    @(negedge clk);
    start = 1'b1;
    e = v.e;
    e.fin = cyc + 17;  // accepted at the next edge, finish 16 edges later
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    if (glitch) begin
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    drain();
  endtask

  initial begin
    int   c0;
    int   pos;
    exp_t e;
    for (int i = 0; i < 16; i++) rom[4'(i)] = 8'h80;

    // in0..3 | row weights | biases | shift8 outs,cls | relu outs,cls | shift0 outs,cls
    add_vec(100, -50, 0, 200, 8'h80, 8'h80, 8'h80, 8'h85, 8'h85, 8'h85,
            5, 5, 5, 0, 5, 5, 5, 0, 5, 5, 5, 0);
    add_vec(100, -50, 0, 200, 8'h80, 8'hFF, 8'h80, 8'h80, 8'h80, 8'h80,
            0, 124, 0, 1, 0, 124, 0, 1, 0, 31750, 0, 1);
    add_vec(100, -50, 0, 200, 8'h80, 8'h01, 8'h80, 8'h80, 8'h80, 8'h80,
            0, -125, 0, 0, 0, 0, 0, 0, 0, -31750, 0, 0);
    add_vec(32767, 32767, 32767, 32767, 8'hFF, 8'hFF, 8'hFF, 8'h80, 8'h80, 8'h80,
            32767, 32767, 32767, 0, 32767, 32767, 32767, 0, 32767, 32767, 32767, 0);
    add_vec(-32768, -32768, -32768, -32768, 8'hFF, 8'hFF, 8'hFF, 8'h80, 8'h80, 8'h80,
            -32768, -32768, -32768, 0, 0, 0, 0, 0, -32768, -32768, -32768, 0);
    add_vec(10, 20, 30, 40, 8'h82, 8'h7E, 8'h83, 8'h7F, 8'h90, 8'h00,
            -1, 15, -127, 1, 0, 15, 0, 1, 199, -184, 172, 0);
    add_vec(1000, 0, 0, 0, 8'h81, 8'h84, 8'h8A, 8'h80, 8'h80, 8'h80,
            3, 15, 39, 2, 3, 15, 39, 2, 1000, 4000, 10000, 2);
    add_vec(256, 0, 0, 0, 8'h80, 8'h85, 8'h85, 8'h80, 8'h80, 8'h80,
            0, 5, 5, 1, 0, 5, 5, 1, 0, 1280, 1280, 1);

    repeat (2) @(negedge clk);
    chk_outs("reset", bus_a.out_act, bus_a.class_idx, '{0, 0, 0}, 0);
    chk("reset_finish", int'(bus_a.finish), 0);
    chk("reset_addr", int'(bus_a.mem_addr), 0);
    rst = 1'b0;

    for (int n = 0; n < vecs.size(); n++) run_vec(vecs[n], 1'b0);

    // start pulsed mid-RUN must not disturb the pass
    run_vec(vecs[1], 1'b1);

    // reset at RUN cycle 5 clears everything at once and suppresses finish
    load_vec(vecs[5]);
    @(negedge clk);
    start = 1'b1;
    e = vecs[5].e;
    e.fin = cyc + 17;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    sb.delete();
    chk_outs("midrst", bus_a.out_act, bus_a.class_idx, '{0, 0, 0}, 0);
    chk("midrst_finish", int'(bus_a.finish), 0);
    chk("midrst_addr", int'(bus_a.mem_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    run_vec(vecs[6], 1'b0);

    // start held high: back-to-back passes, 17 cycles apart, address walk checked
    load_vec(vecs[7]);
    @(negedge clk);
    start = 1'b1;
    c0 = cyc + 1;
    for (int n = 0; n < 3; n++) begin
      e = vecs[7].e;
      e.fin = c0 + 16 + 17 * n;
      sb.push_back(e);
    end
    chk("addr_idle", int'(bus_a.mem_addr), 0);
    for (int s = 0; s < 18; s++) begin
      @(negedge clk);
      pos = s % 17;
      chk($sformatf("addr_step%0d", s), int'(bus_a.mem_addr), (pos < 14) ? pos + 1 : 0);
    end
    while (cyc < c0 + 40) @(negedge clk);
    start = 1'b0;
    drain();
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
